// File: rtl/mdio_link_poll.sv
// MDIO management sequencer: writes a config word to every PHY once, then sweeps
// their status registers forever, keeping a per-PHY link vector with change pulse.
module mdio_link_poll #(
    parameter int          PHY_NUM       = 4,
    parameter int          PHY_BASE_ADDR = 0,
    parameter int          CFG_REG_ADDR  = 0,
    parameter logic [15:0] CFG_DATA      = 16'h0100,
    parameter int          STAT_REG_ADDR = 1,
    parameter int          LINK_BIT      = 2,
    parameter int          POLL_GAP      = 1000,
    parameter int          TIMEOUT       = 4096
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               start_flag,
    input  logic               stop_flag,
    output logic               mdio_start_flag,
    output logic               r_w,
    output logic [4:0]         phy_add,
    output logic [4:0]         reg_add,
    output logic [15:0]        write_reg_data,
    input  logic [15:0]        read_reg_data,
    input  logic               mdio_end_flag,
    output logic [PHY_NUM-1:0] link_vec,
    output logic               link_change,
    output logic               cfg_done,
    output logic               busy,
    output logic               timeout_err
);
    localparam int IW = (PHY_NUM > 1) ? $clog2(PHY_NUM) : 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam int GW = $clog2(POLL_GAP + 1);

    typedef enum logic [2:0] {IDLE, CFG_REQ, CFG_WAIT, POLL_REQ, POLL_WAIT, GAP} state_t;

    state_t        state, state_nx;
    logic [IW-1:0] idx;
    logic [TW-1:0] wait_cnt;
    logic [GW-1:0] gap_cnt;
    logic          stop_pend, chg_pend;
    logic          in_wait, tmo_hit, done, last, stop_now, new_bit;
    logic [4:0]    cur_phy;
    logic          unused_rd;

    assign in_wait  = (state == CFG_WAIT) || (state == POLL_WAIT);
    // end_flag wins over a timeout landing in the same cycle
    assign tmo_hit  = in_wait && !mdio_end_flag && (wait_cnt == TW'(TIMEOUT - 1));
    assign done     = in_wait && (mdio_end_flag || tmo_hit);
    assign last     = (idx == IW'(PHY_NUM - 1));
    assign stop_now = stop_pend || stop_flag;
    assign new_bit  = mdio_end_flag && read_reg_data[LINK_BIT];
    assign cur_phy  = 5'(PHY_BASE_ADDR) + 5'(idx);
    assign busy     = (state != IDLE);
    // only the link bit of the status word matters
    assign unused_rd = ^read_reg_data;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= IDLE;
        else            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (start_flag && !stop_flag) state_nx = CFG_REQ;
            CFG_REQ:   state_nx = stop_flag ? IDLE : CFG_WAIT;
            CFG_WAIT:  if (done) state_nx = stop_now ? IDLE : (last ? POLL_REQ : CFG_REQ);
            POLL_REQ:  state_nx = stop_flag ? IDLE : POLL_WAIT;
            POLL_WAIT: if (done) state_nx = stop_now ? IDLE : (last ? GAP : POLL_REQ);
            GAP: begin
                if (stop_flag)                      state_nx = IDLE;
                else if (gap_cnt == GW'(POLL_GAP)) state_nx = POLL_REQ;
            end
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mdio_start_flag <= 1'b0;
            r_w             <= 1'b1;
            phy_add         <= '0;
            reg_add         <= '0;
            write_reg_data  <= '0;
            link_vec        <= '0;
            link_change     <= 1'b0;
            cfg_done        <= 1'b0;
            timeout_err     <= 1'b0;
            idx             <= '0;
            wait_cnt        <= '0;
            gap_cnt         <= '0;
            stop_pend       <= 1'b0;
            chg_pend        <= 1'b0;
        end else begin
            mdio_start_flag <= 1'b0;
            chg_pend        <= 1'b0;
            link_change     <= chg_pend;
            gap_cnt         <= (state == GAP) ? gap_cnt + 1'b1 : '0;
            case (state)
                IDLE: if (start_flag && !stop_flag) begin
                    idx         <= '0;
                    timeout_err <= 1'b0;
                    cfg_done    <= 1'b0;
                end
                CFG_REQ, POLL_REQ: begin
                    wait_cnt <= '0;
                    if (!stop_flag) begin
                        mdio_start_flag <= 1'b1;
                        r_w             <= (state == POLL_REQ);
                        phy_add         <= cur_phy;
                        reg_add         <= (state == POLL_REQ) ? 5'(STAT_REG_ADDR) : 5'(CFG_REG_ADDR);
                        if (state == CFG_REQ) write_reg_data <= CFG_DATA;
                    end
                end
                CFG_WAIT, POLL_WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (stop_flag) stop_pend   <= 1'b1;
                    if (tmo_hit)   timeout_err <= 1'b1;
                    if (done) begin
                        idx <= last ? '0 : idx + 1'b1;
                        if (state == POLL_WAIT) begin
                            link_vec[idx] <= new_bit;
                            chg_pend      <= (link_vec[idx] != new_bit);
                        end else if (last) begin
                            cfg_done <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
            if (state_nx == IDLE) begin
                cfg_done  <= 1'b0;
                stop_pend <= 1'b0;
            end
        end
    end
endmodule
